// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with bounded memory wait.
// Optional perf counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module multicycle_control_fsm #(
   parameter int unsigned MEM_WAIT_MAX = 255,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             neg,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             illegal_op,
   output logic             bus_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL,
      S_ALUWB,
      S_BEQ
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_state;
   logic              timeout;
   logic              taken;

   assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

   always_comb begin
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = neg;
         default: taken = 1'b0;
      endcase
   end

   // wait_cnt is zero outside memory states, so clearing on any non-stall cycle covers state exit
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (mem_state && !mem_ready && !timeout)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
               7'b0110011:             state_nxt = S_EXECUTER;
               7'b0010011:             state_nxt = S_EXECUTEI;
               7'b1101111:             state_nxt = S_JAL;
               7'b1100011:             state_nxt = S_BEQ;
               default:                state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
         S_MEMWB:    state_nxt = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
         S_EXECUTER: state_nxt = S_ALUWB;
         S_EXECUTEI: state_nxt = S_ALUWB;
         S_JAL:      state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = S_FETCH;
         S_BEQ:      state_nxt = S_FETCH;
         default:    state_nxt = S_FETCH;
      endcase
      if (timeout)
         state_nxt = S_FETCH;
   end

   always_comb begin
      mem_req    = 1'b0;
      ALUOp      = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      illegal_op = 1'b0;
      bus_err    = timeout;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               7'b0000011, 7'b0100011, 7'b0110011,
               7'b0010011, 7'b1101111, 7'b1100011: illegal_op = 1'b0;
               default:                            illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = !timeout;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            PCWrite = taken;
         end
         default: ;
      endcase
      // Reset presents the FETCH select pattern with every enable held low
      if (reset) begin
         mem_req    = 1'b0;
         ALUOp      = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b10;
         ResultSrc  = 2'b10;
         AdrSrc     = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         MemWrite   = 1'b0;
         illegal_op = 1'b0;
         bus_err    = 1'b0;
      end
   end

`ifdef MC_CTRL_PERF_CNT_EN
   logic instret_inc;

   assign instret_inc = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                        ((state == S_MEMWRITE) && mem_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (instret_inc)
            instret_cnt <= instret_cnt + 1'b1;
      end
   end
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each fetched instruction expands into a
// plan of step letters, and expected outputs are derived per step from the control table.
module tb_multicycle_control_fsm;

   localparam int unsigned MAXW  = 3;
   localparam int unsigned CW    = 8;
   localparam int unsigned NCYC  = 4000;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic          zero, neg, mem_ready;
   logic          mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op, bus_err;
   logic [1:0]    ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
   logic [CW-1:0] cycle_cnt, instret_cnt;

   multicycle_control_fsm #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .neg(neg),
      .mem_ready(mem_ready), .mem_req(mem_req), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_op(illegal_op),
      .bus_err(bus_err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: remaining steps of the current instruction; empty plan means fetching
   string       plan = "";
   int unsigned pos  = 0;
   int unsigned wc   = 0;
   int unsigned cyc  = 0;
   int unsigned ins  = 0;

   function automatic string plan_for(input logic [6:0] o);
      case (o)
         7'b0000011: return "DARB";
         7'b0100011: return "DAW";
         7'b0110011: return "DXU";
         7'b0010011: return "DIU";
         7'b1101111: return "DJU";
         7'b1100011: return "DQ";
         default:    return "D";
      endcase
   endfunction

   function automatic byte cur_step();
      if (pos < plan.len()) return plan[pos];
      return "F";
   endfunction

   function automatic logic branch_taken(input logic [2:0] f, input logic z, input logic n);
      return (f == 3'd0 && z) || (f == 3'd1 && !z) || (f == 3'd4 && n);
   endfunction

   task automatic check_outputs();
      byte  s;
      logic is_mem, to;
      logic e_req, e_adr, e_irw, e_pcw, e_rw, e_mw, e_ill;
      logic [1:0] e_aop, e_sa, e_sb, e_rs;
      s      = cur_step();
      is_mem = (s == "F") || (s == "R") || (s == "W");
      to     = is_mem && !mem_ready && (wc == MAXW);
      {e_req, e_adr, e_irw, e_pcw, e_rw, e_mw, e_ill} = '0;
      {e_aop, e_sa, e_sb, e_rs} = '0;
      if (reset) begin
         e_sb = 2'b10; e_rs = 2'b10; to = 1'b0;
      end else begin
         case (s)
            "F": begin e_req = 1; e_sb = 2'b10; e_rs = 2'b10; e_irw = mem_ready; e_pcw = mem_ready; end
            "D": begin e_sa = 2'b01; e_sb = 2'b01; e_ill = (plan_for(op) == "D"); end
            "A": begin e_sa = 2'b10; e_sb = 2'b01; end
            "R": begin e_req = 1; e_adr = 1; end
            "B": begin e_rs = 2'b01; e_rw = 1; end
            "W": begin e_req = 1; e_adr = 1; e_mw = !to; end
            "X": begin e_sa = 2'b10; e_aop = 2'b10; end
            "I": begin e_sa = 2'b10; e_sb = 2'b01; e_aop = 2'b10; end
            "J": begin e_sa = 2'b01; e_sb = 2'b10; e_pcw = 1; end
            "U": e_rw = 1;
            "Q": begin e_sa = 2'b10; e_aop = 2'b01; e_pcw = branch_taken(funct3, zero, neg); end
            default: ;
         endcase
      end
      check_eq("mem_req",    32'(mem_req),    32'(e_req));
      check_eq("ALUOp",      32'(ALUOp),      32'(e_aop));
      check_eq("ALUSrcA",    32'(ALUSrcA),    32'(e_sa));
      check_eq("ALUSrcB",    32'(ALUSrcB),    32'(e_sb));
      check_eq("ResultSrc",  32'(ResultSrc),  32'(e_rs));
      check_eq("AdrSrc",     32'(AdrSrc),     32'(e_adr));
      check_eq("IRWrite",    32'(IRWrite),    32'(e_irw));
      check_eq("PCWrite",    32'(PCWrite),    32'(e_pcw));
      check_eq("RegWrite",   32'(RegWrite),   32'(e_rw));
      check_eq("MemWrite",   32'(MemWrite),   32'(e_mw));
      check_eq("illegal_op", 32'(illegal_op), 32'(e_ill));
      check_eq("bus_err",    32'(bus_err),    32'(to));
`ifdef MC_CTRL_PERF_CNT_EN
      check_eq("cycle_cnt",   32'(cycle_cnt),   cyc % (1 << CW));
      check_eq("instret_cnt", 32'(instret_cnt), ins % (1 << CW));
`else
      check_eq("cycle_cnt",   32'(cycle_cnt),   32'd0);
      check_eq("instret_cnt", 32'(instret_cnt), 32'd0);
`endif
   endtask

   task automatic advance_model();
      byte  s;
      logic is_mem;
      if (reset) begin
         plan = ""; pos = 0; wc = 0; cyc = 0; ins = 0;
         return;
      end
      cyc++;
      s      = cur_step();
      is_mem = (s == "F") || (s == "R") || (s == "W");
      if (is_mem && !mem_ready) begin
         if (wc == MAXW) begin
            plan = ""; pos = 0; wc = 0;
         end else
            wc++;
      end else begin
         wc = 0;
         if (s == "F") begin
            plan = plan_for(op); pos = 0;
         end else begin
            pos++;
            if (s == "B" || s == "U" || s == "Q" || s == "W") ins++;
            if (pos >= plan.len()) begin plan = ""; pos = 0; end
         end
      end
   endtask

   logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1101111, 7'b1100011, 7'b1110011, 7'b0000000};

   initial begin
      int unsigned stall = 0;
      int unsigned rst_left = 2;
      op = 7'b0110011; funct3 = '0; zero = 0; neg = 0; mem_ready = 1; reset = 1;
      for (int unsigned i = 0; i < NCYC; i++) begin
         reset = (rst_left != 0);
         if (rst_left != 0) rst_left--;
         if (!reset && $urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 2);
         if (cur_step() == "F") begin
            op     = ops[$urandom_range(0, 7)];
            funct3 = 3'($urandom_range(0, 7));
         end
         zero = 1'($urandom);
         neg  = 1'($urandom);
         if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(2, 6);
         if (stall != 0) begin
            mem_ready = 1'b0; stall--;
         end else
            mem_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         check_outputs();
         advance_model();
         @(posedge clk);
         #1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
